// File: rtl/fifo_package.sv
// Shared FIFO definitions: default word width and the pop-reader state encoding.
package fifo_package;

  localparam int FIFO_DATA_WIDTH = 32;

  typedef logic [1:0] fifo_reader_state_t;

  localparam fifo_reader_state_t IDLE   = 2'd0;
  localparam fifo_reader_state_t ACTIVE = 2'd1;
  localparam fifo_reader_state_t FLUSH  = 2'd2;

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry in-order register buffer for the FIFO pop reader; entry0 is always the head.
module fifo_reader_buf
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] entry0_r;
  logic [DATA_WIDTH-1:0] entry1_r;
  logic [1:0]            occ_r;

  // Shift-style storage: a pop moves entry1 forward, a push lands behind the last valid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry0_r <= '0;
      entry1_r <= '0;
      occ_r    <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_r == 2'd0) begin
            entry0_r <= push_data;
          end else begin
            entry1_r <= push_data;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          entry0_r <= entry1_r;
          occ_r    <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            entry0_r <= push_data;
          end else begin
            entry0_r <= entry1_r;
            entry1_r <= push_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  assign occ  = occ_r;
  assign head = entry0_r;

endmodule

// File: rtl/fifo_pop_reader.sv
// Drains the FIFO pop port and repacks words into BURST_LEN-beat bursts on a valid/ready stream.
// Optional FIFO_READER_TIMEOUT_EN: hold back a lone word and close idle partial bursts via FLUSH.
module fifo_pop_reader
  import fifo_package::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pop_valid_i,
  output logic                  pop_grant_o,
  input  logic [DATA_WIDTH-1:0] pop_data_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  if (BURST_LEN < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_pop_reader: BURST_LEN must be >= 2 and TIMEOUT >= 1");
  end

  fifo_reader_state_t state_r;
  fifo_reader_state_t state_nxt_s;
  logic               inflight_r;
  logic [BEAT_W-1:0]  beat_cnt_r;
  logic [1:0]         occ_s;
  logic [1:0]         occ_after_s;
  logic               pop_hs_s;
  logic               out_hs_s;
  logic               last_beat_s;
  logic               more_work_s;
  logic               timeout_s;

  // Never grant more than the buffer can absorb once the in-flight read lands.
  assign pop_grant_o = rst_n && (({1'b0, occ_s} + {2'b00, inflight_r}) < 3'd2);
  assign pop_hs_s    = pop_valid_i && pop_grant_o;
  assign out_hs_s    = out_valid_o && out_ready_i;
  assign last_beat_s = (beat_cnt_r == BEAT_LAST);
  assign out_last_o  = last_beat_s || (state_r == FLUSH);
  assign busy_o      = (state_r != IDLE) || (occ_s != 2'd0) || inflight_r;
  assign occ_after_s = occ_s - {1'b0, out_hs_s} + {1'b0, inflight_r};
  assign more_work_s = (occ_after_s != 2'd0) || pop_hs_s;

  fifo_reader_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_r),
    .push_data(pop_data_i),
    .pop      (out_hs_s),
    .occ      (occ_s),
    .head     (out_data_o)
  );

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  logic [IDLE_W-1:0] idle_cnt_r;

  // A lone head word waits for a companion, the burst end, or the flush.
  assign out_valid_o = (occ_s != 2'd0) &&
                       ((occ_s == 2'd2) || inflight_r || last_beat_s || (state_r == FLUSH));
  assign timeout_s   = (state_r == ACTIVE) && (idle_cnt_r == IDLE_MAX);

  // Idle counter: counts cycles a partial burst sits on a single buffered word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
    end else if (state_r != ACTIVE || pop_hs_s) begin
      idle_cnt_r <= '0;
    end else if (occ_s == 2'd1 && !inflight_r && idle_cnt_r != IDLE_MAX) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end
`else
  assign out_valid_o = (occ_s != 2'd0);
  assign timeout_s   = 1'b0;
`endif

  // Burst FSM next state; a closing beat with more words pending keeps the burst open.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_hs_s) state_nxt_s = ACTIVE;
        else          state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (out_hs_s && out_last_o) state_nxt_s = more_work_s ? ACTIVE : IDLE;
        else if (timeout_s)         state_nxt_s = FLUSH;
        else                        state_nxt_s = ACTIVE;
      end
      FLUSH: begin
        if (out_hs_s) state_nxt_s = more_work_s ? ACTIVE : IDLE;
        else          state_nxt_s = FLUSH;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, read-in-flight flag and beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      inflight_r <= 1'b0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= pop_hs_s;
      if (out_hs_s) begin
        beat_cnt_r <= out_last_o ? '0 : beat_cnt_r + BEAT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

endmodule
